pc_unit: RTL
============

Name: pc_unit

Overview:
- Parametrised program-counter unit for the multicycle CPU. Generalises the plain enabled PC register.
- Adds four next-PC modes, a fetch request/acknowledge handshake, exception redirect with EPC capture, and exception return.
- Sits between the control FSM/datapath and the instruction memory port. Drives the fetch address and holds it stable until memory acknowledges.

Parameters:
- ADDR_W, 32, width of PC and all address operands.
- ALIGN_BITS, 2, log2 of instruction size; sequential increment INC = 2**ALIGN_BITS.
- RESET_VECTOR, 32'h0000_0000, PC value after reset (truncated to ADDR_W).
- EXC_VECTOR, 32'h0000_0180, PC value on exception entry (truncated to ADDR_W).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_en  in  1  advance PC; sampled only in HOLD.
- sel  in  2  next-PC mode: 00 sequential, 01 branch, 10 jump, 11 register jump.
- branch_off  in  ADDR_W  branch byte offset, already sign-extended and shifted.
- jump_target  in  ADDR_W  absolute jump address.
- reg_target  in  ADDR_W  register-jump address.
- exc_req  in  1  exception request pulse.
- eret  in  1  exception return; sampled only in HOLD.
- fetch_ack  in  1  instruction memory has returned data for pc.
- pc  out  ADDR_W  current fetch address.
- pc_plus  out  ADDR_W  pc + INC, combinational.
- epc  out  ADDR_W  saved exception PC.
- fetch_req  out  1  fetch request; high in FETCH.
- fetch_valid  out  1  instruction at pc is available; high in HOLD.
- exc_pending  out  1  exception latched during FETCH, not yet taken.
- misaligned  out  1  one-cycle pulse, misaligned target (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (synchronous, highest priority, also mid-fetch): pc=RESET_VECTOR, epc=0, state=FETCH, exc_pending=0, misaligned=0. fetch_req is therefore 1 in the first cycle after reset.
- Arithmetic is modulo 2^ADDR_W; wrap-around is silent.
  - sequential: next = pc+INC
  - branch: next = pc+INC+branch_off
  - jump: next = jump_target
  - register jump: next = reg_target
- Outputs are decoded from state: FETCH gives fetch_req=1, fetch_valid=0; HOLD gives fetch_req=0, fetch_valid=1.
- pc changes only on the transitions listed below; it is held stable throughout FETCH until fetch_ack.

FETCH state:
- exc_req and fetch_ack together: epc<=pc, pc<=EXC_VECTOR, stay FETCH. The fetched word is discarded.
- exc_req alone, no pending: epc<=pc, exc_pending<=1.
- exc_req alone, already pending: ignored; epc unchanged.
- fetch_ack with exc_pending=1: pc<=EXC_VECTOR, exc_pending<=0, stay FETCH. The fetched word is discarded; fetch_valid never rises.
- fetch_ack with exc_pending=0: go to HOLD.
- pc_en, eret and sel are ignored.

HOLD state (priority exc_req > eret > pc_en):
- exc_req: epc<=pc, pc<=EXC_VECTOR, go to FETCH.
- eret: pc<=epc, go to FETCH.
- pc_en: pc<=next, go to FETCH.
- none asserted: stay in HOLD, pc held.
- fetch_ack is ignored.

Latency:
- One cycle from a qualifying input to the updated pc and fetch_req.
- Minimum instruction period is 2 cycles (FETCH with immediate ack, then HOLD with pc_en).

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Applies in HOLD with pc_en, for any sel other than 00, when next[ALIGN_BITS-1:0] != 0.
  - Action: epc<=pc, pc<=EXC_VECTOR, go to FETCH, misaligned pulses 1 for one cycle.
  - eret targets are not checked.
- Not defined:
  - Targets load unmodified, including low bits.
  - misaligned is constant 0.

Test Plan:
- Sequential fetch: reset, then ack one cycle later, then pc_en with sel=00, repeated three times -> pc 0x0, 0x4, 0x8, 0xC. fetch_req/fetch_valid alternate 1/0 and 0/1.
- Branch and jump from pc=0x100:
  - branch_off=0xFFFFFFF8, sel=01 -> pc=0xFC.
  - Then sel=10 with jump_target=0x2000 -> pc=0x2000.
  - Then sel=11 with reg_target=0x40 -> pc=0x40.
- Wrap: pc=0xFFFFFFFC, sel=00 -> pc=0x0.
- Stalled fetch with exception: pc=0x200 in FETCH, ack held low 5 cycles, exc_req pulsed in cycle 2 -> pc stays 0x200, exc_pending=1, epc=0x200. When ack arrives: pc=0x180, exc_pending=0, fetch_valid stays 0.
- Exception then eret: in HOLD at pc=0x300, exc_req=1 together with pc_en=1 -> pc=0x180, epc=0x300. After ack, eret=1 -> pc=0x300.
- Reset mid-fetch and alignment:
  - reset asserted during FETCH with exc_pending=1 -> pc=RESET_VECTOR, epc=0, exc_pending=0 next cycle.
  - With PC_ALIGN_CHECK_EN defined, sel=10, jump_target=0x1002 -> pc=0x180, misaligned pulses once.
  - Without the macro, the same stimulus gives pc=0x1002.

Source files
------------

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- program-counter unit for the multicycle CPU.
//
// Holds the fetch address and drives a request/acknowledge handshake to the
// instruction memory. It has two states:
//   FETCH : fetch_req=1. pc is held until fetch_ack. Exceptions that arrive
//           here are latched in exc_pending and taken when the ack arrives.
//   HOLD  : fetch_valid=1. The word at pc is available. The priority is
//           exc_req > eret > pc_en.
//
// There are four next-PC modes (sel):
//   00 pc+INC, 01 pc+INC+branch_off, 10 jump_target, 11 reg_target.
// Arithmetic wraps silently modulo 2^ADDR_W.
//
// Optional build macro PC_ALIGN_CHECK_EN:
//   When defined, a non-sequential pc_en target with non-zero low ALIGN_BITS
//   raises an exception instead of loading, and misaligned pulses for one
//   cycle. When undefined, targets load unmodified and misaligned is tied 0.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   pc_en, sel                 advance request and next-PC mode (used in HOLD)
//   branch_off, jump_target,
//   reg_target                 next-PC operands
//   exc_req, eret              exception request / exception return
//   fetch_ack                  memory has returned the word at pc
//   pc, pc_plus, epc           fetch address, pc+INC, saved exception PC
//   fetch_req, fetch_valid     state-decoded handshake outputs
//   exc_pending, misaligned    latched exception / misaligned-target pulse
// ---------------------------------------------------------------------------
module pc_unit #(
  parameter int          ADDR_W       = 32,
  parameter int          ALIGN_BITS   = 2,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_en,
  input  logic [1:0]        sel,
  input  logic [ADDR_W-1:0] branch_off,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              exc_req,
  input  logic              eret,
  input  logic              fetch_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus,
  output logic [ADDR_W-1:0] epc,
  output logic              fetch_req,
  output logic              fetch_valid,
  output logic              exc_pending,
  output logic              misaligned
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VECTOR);
  localparam logic [ADDR_W-1:0] EXC_PC = ADDR_W'(EXC_VECTOR);
  localparam logic [ADDR_W-1:0] INC    = ADDR_W'(1) << ALIGN_BITS;

  typedef enum logic {FETCH, HOLD} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] epc_reg, epc_next;
  logic              pend_reg, pend_next;
  logic [ADDR_W-1:0] target;

  assign pc_plus = pc_reg + INC;

  // Next-PC target for the selected mode.
  always_comb begin
    target = pc_plus;
    case (sel)
      2'b00: target = pc_plus;
      2'b01: target = pc_plus + branch_off;
      2'b10: target = jump_target;
      2'b11: target = reg_target;
      default: target = pc_plus;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [ADDR_W-1:0] ALIGN_MASK = INC - ADDR_W'(1);
  logic mis_reg, mis_next;
  logic target_bad;

  // Sequential targets are aligned by construction, so only the other modes
  // are checked.
  assign target_bad = (sel != 2'b00) && ((target & ALIGN_MASK) != '0);
`endif

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    epc_next   = epc_reg;
    pend_next  = pend_reg;
`ifdef PC_ALIGN_CHECK_EN
    mis_next   = 1'b0;
`endif
    case (state_reg)
      FETCH: begin
        if (exc_req && fetch_ack) begin
          // The fetched word is dropped and the exception is taken now.
          epc_next  = pc_reg;
          pc_next   = EXC_PC;
          pend_next = 1'b0;
        end else if (exc_req) begin
          // Only the first request captures epc. pc cannot move in FETCH.
          if (!pend_reg) begin
            epc_next  = pc_reg;
            pend_next = 1'b1;
          end
        end else if (fetch_ack) begin
          if (pend_reg) begin
            // The latched exception consumes the ack. HOLD is never entered.
            pc_next   = EXC_PC;
            pend_next = 1'b0;
          end else begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (exc_req) begin
          epc_next   = pc_reg;
          pc_next    = EXC_PC;
          state_next = FETCH;
        end else if (eret) begin
          pc_next    = epc_reg;
          state_next = FETCH;
        end else if (pc_en) begin
`ifdef PC_ALIGN_CHECK_EN
          if (target_bad) begin
            epc_next = pc_reg;
            pc_next  = EXC_PC;
            mis_next = 1'b1;
          end else begin
            pc_next  = target;
          end
`else
          pc_next    = target;
`endif
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FETCH;
      pc_reg    <= RST_PC;
      epc_reg   <= '0;
      pend_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      epc_reg   <= epc_next;
      pend_reg  <= pend_next;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) mis_reg <= 1'b0;
    else       mis_reg <= mis_next;
  end
  assign misaligned = mis_reg;
`else
  assign misaligned = 1'b0;
`endif

  assign pc          = pc_reg;
  assign epc         = epc_reg;
  assign exc_pending = pend_reg;
  assign fetch_req   = (state_reg == FETCH);
  assign fetch_valid = (state_reg == HOLD);

endmodule
